// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM responder with wait states, busy/done handshake and illegal-request flagging
module data_mem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  mem_read_enable,
   input  logic                  mem_write_enable,
   input  logic [31:0]           mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_write_data_in,
   output logic [DATA_WIDTH-1:0] mem_read_data_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t                  state, state_next;
   logic [CW-1:0]           count;
   logic                    op_write;
   logic [ADDR_WIDTH-1:0]   index;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH-1:0]   ram [DEPTH];

   logic request, illegal, accept, access;
   logic busy_next, done_next, err_next;

   assign request = mem_read_enable | mem_write_enable;
   assign illegal = (mem_read_enable & mem_write_enable)
                  | (mem_addr[1:0] != 2'b00)
                  | (mem_addr[31:ADDR_WIDTH+2] != '0);
   assign accept  = (state == S_IDLE) && request && !illegal;
   assign access  = (state == S_WAIT) && (count == '0);

   // State register plus the datapath latched at accept
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state             <= S_IDLE;
         count             <= '0;
         mem_read_data_out <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         err               <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= busy_next;
         done  <= done_next;
         err   <= err_next;
         if (accept) begin
            op_write <= mem_write_enable;
            index    <= mem_addr[ADDR_WIDTH+1:2];
            wdata    <= mem_write_data_in;
            count    <= CW'(WAIT_STATES);
         end else if ((state == S_WAIT) && (count != '0)) begin
            count <= count - CW'(1);
         end
         if (access && !op_write)
            mem_read_data_out <= ram[index];
      end
   end

   // Reset on the access edge aborts the write
   always_ff @(posedge Clk) begin
      if (!Reset && access && op_write)
         ram[index] <= wdata;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: if (request) state_next = illegal ? S_DONE : S_WAIT;
         S_WAIT: if (count == '0) state_next = S_DONE;
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy_next = 1'b0;
      done_next = 1'b0;
      err_next  = 1'b0;
      case (state)
         S_IDLE: begin
            busy_next = request && !illegal;
            done_next = request && illegal;
            err_next  = request && illegal;
         end
         S_WAIT: begin
            busy_next = (count != '0);
            done_next = (count == '0);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

   localparam int WS1 = 2;
   localparam int WS0 = 0;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        re [2];
   logic        we [2];
   logic [31:0] addr [2];
   logic [31:0] wd [2];
   logic [31:0] rdo [2];
   logic        busy [2];
   logic        done [2];
   logic        err [2];

   logic [31:0] mem_m [int];
   logic [31:0] last_rd [2];
   int          known1 [$];
   int          errors = 0;
   int          checks = 0;

   always #5 Clk = ~Clk;

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS0), .DATA_WIDTH(32)) u0 (
      .Clk(Clk), .Reset(Reset),
      .mem_read_enable(re[0]), .mem_write_enable(we[0]),
      .mem_addr(addr[0]), .mem_write_data_in(wd[0]),
      .mem_read_data_out(rdo[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS1), .DATA_WIDTH(32)) u1 (
      .Clk(Clk), .Reset(Reset),
      .mem_read_enable(re[1]), .mem_write_enable(we[1]),
      .mem_addr(addr[1]), .mem_write_data_in(wd[1]),
      .mem_read_data_out(rdo[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   function automatic int key(input int sel, input logic [31:0] a);
      return sel * 4096 + int'(a[11:2]);
   endfunction

   // Holds the request until done is seen; reports what it observed, no judging
   task automatic xact(input int sel, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, output int done_cyc, output int busy_cnt,
                       output bit err_s, output logic [31:0] rd_s);
      done_cyc = 0; busy_cnt = 0; err_s = 0; rd_s = '0;
      @(negedge Clk);
      re[sel] = r; we[sel] = w; addr[sel] = a; wd[sel] = d;
      for (int c = 1; c <= 30; c++) begin
         @(negedge Clk);
         if (busy[sel]) busy_cnt++;
         if (done[sel]) begin
            done_cyc = c; err_s = err[sel]; rd_s = rdo[sel];
            break;
         end
      end
      re[sel] = 0; we[sel] = 0;
   endtask

   task automatic test_reset;
      Reset = 1;
      for (int s = 0; s < 2; s++) begin re[s] = 0; we[s] = 0; addr[s] = 0; wd[s] = 0; end
      @(negedge Clk); @(negedge Clk);
      Reset = 0;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (busy[s] !== 0 || done[s] !== 0 || err[s] !== 0 || rdo[s] !== 0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: busy=%b done=%b err=%b rd=%h, required all 0", s, busy[s], done[s], err[s], rdo[s]);
         end
      end
      repeat (5) @(negedge Clk);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (busy[s] !== 0 || done[s] !== 0 || err[s] !== 0 || rdo[s] !== 0) begin
            errors++;
            $display("FAIL reset_idle dut%0d: busy=%b done=%b err=%b rd=%h, required all 0", s, busy[s], done[s], err[s], rdo[s]);
         end
      end
      last_rd[0] = 0; last_rd[1] = 0;
   endtask

   task automatic test_write_read;
      int dc, bc; bit e; logic [31:0] r;
      xact(1, 0, 1, 32'h10, 32'hDEADBEEF, dc, bc, e, r);
      mem_m[key(1, 32'h10)] = 32'hDEADBEEF; known1.push_back(4);
      checks++;
      if (dc !== WS1 + 2 || bc !== WS1 + 1 || e !== 0) begin
         errors++;
         $display("FAIL write_timing: done_cycle=%0d busy=%0d err=%b, required %0d %0d 0", dc, bc, e, WS1 + 2, WS1 + 1);
      end
      xact(1, 1, 0, 32'h10, 32'h0, dc, bc, e, r);
      last_rd[1] = 32'hDEADBEEF;
      checks++;
      if (dc !== WS1 + 2 || bc !== WS1 + 1 || e !== 0 || r !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL read_back: done_cycle=%0d busy=%0d err=%b data=%h, required %0d %0d 0 deadbeef", dc, bc, e, r, WS1 + 2, WS1 + 1);
      end
   endtask

   task automatic test_errors;
      int dc, bc; bit e; logic [31:0] r, v;
      logic [31:0] ea [3];
      bit er [3], ew [3];
      v = $urandom;
      xact(1, 0, 1, 32'h20, v, dc, bc, e, r);
      mem_m[key(1, 32'h20)] = v; known1.push_back(8);
      ea[0] = 32'h12;   er[0] = 1; ew[0] = 0;
      ea[1] = 32'h1000; er[1] = 1; ew[1] = 0;
      ea[2] = 32'h20;   er[2] = 1; ew[2] = 1;
      for (int i = 0; i < 3; i++) begin
         xact(1, er[i], ew[i], ea[i], 32'hFFFF_FFFF, dc, bc, e, r);
         checks++;
         if (dc !== 1 || bc !== 0 || e !== 1 || r !== last_rd[1]) begin
            errors++;
            $display("FAIL illegal_%0d: done_cycle=%0d busy=%0d err=%b data=%h, required 1 0 1 %h", i, dc, bc, e, r, last_rd[1]);
         end
         @(negedge Clk);
         checks++;
         if (done[1] !== 0 || err[1] !== 0) begin
            errors++;
            $display("FAIL illegal_pulse_%0d: done=%b err=%b after pulse, required 0 0", i, done[1], err[1]);
         end
      end
      xact(1, 1, 0, 32'h20, 32'h0, dc, bc, e, r);
      last_rd[1] = v;
      checks++;
      if (r !== v || e !== 0) begin
         errors++;
         $display("FAIL error_no_write: data=%h err=%b, required %h 0", r, e, v);
      end
   endtask

   task automatic test_midflight;
      int dc, bc; bit e; logic [31:0] r, v40;
      v40 = $urandom;
      xact(1, 0, 1, 32'h40, v40, dc, bc, e, r);
      mem_m[key(1, 32'h40)] = v40; known1.push_back(16);
      xact(1, 0, 1, 32'h10, 32'h5555_AAAA, dc, bc, e, r);
      @(negedge Clk);
      we[1] = 1; addr[1] = 32'h10; wd[1] = 32'hDEADBEEF;
      @(negedge Clk);
      addr[1] = 32'h40; wd[1] = 32'h1;
      dc = 0;
      for (int c = 2; c <= 30; c++) begin
         @(negedge Clk);
         if (done[1]) begin dc = c; break; end
      end
      we[1] = 0;
      mem_m[key(1, 32'h10)] = 32'hDEADBEEF;
      checks++;
      if (dc !== WS1 + 2) begin
         errors++;
         $display("FAIL midflight_timing: done_cycle=%0d, required %0d", dc, WS1 + 2);
      end
      xact(1, 1, 0, 32'h10, 32'h0, dc, bc, e, r);
      checks++;
      if (r !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL midflight_latched: data=%h, required deadbeef", r);
      end
      xact(1, 1, 0, 32'h40, 32'h0, dc, bc, e, r);
      last_rd[1] = v40;
      checks++;
      if (r !== v40) begin
         errors++;
         $display("FAIL midflight_other: data=%h, required %h", r, v40);
      end
   endtask

   task automatic test_reset_abort;
      int dc, bc; bit e; logic [31:0] r, v8;
      v8 = $urandom;
      xact(1, 0, 1, 32'h8, v8, dc, bc, e, r);
      mem_m[key(1, 32'h8)] = v8; known1.push_back(2);
      @(negedge Clk);
      we[1] = 1; addr[1] = 32'h8; wd[1] = 32'h12345678;
      // Access edge is WS1+1 edges after accept
      repeat (WS1 + 1) @(negedge Clk);
      Reset = 1; we[1] = 0;
      @(negedge Clk);
      Reset = 0;
      last_rd[0] = 0; last_rd[1] = 0;
      checks++;
      if (busy[1] !== 0 || done[1] !== 0 || rdo[1] !== 0) begin
         errors++;
         $display("FAIL abort_outputs: busy=%b done=%b rd=%h, required 0 0 0", busy[1], done[1], rdo[1]);
      end
      xact(1, 1, 0, 32'h8, 32'h0, dc, bc, e, r);
      last_rd[1] = v8;
      checks++;
      if (r !== v8 || dc !== WS1 + 2) begin
         errors++;
         $display("FAIL abort_no_write: data=%h done_cycle=%0d, required %h %0d", r, dc, v8, WS1 + 2);
      end
   endtask

   task automatic test_back_to_back;
      int dc, bc; bit e; logic [31:0] r, w;
      int period;
      bit exp_done, exp_busy;
      period = WS0 + 3;
      w = $urandom;
      xact(0, 0, 1, 32'h4, w, dc, bc, e, r);
      mem_m[key(0, 32'h4)] = w;
      @(negedge Clk);
      re[0] = 1; addr[0] = 32'h4;
      for (int c = 1; c <= 12; c++) begin
         @(negedge Clk);
         exp_busy = (c % period) >= 1 && (c % period) <= WS0 + 1;
         exp_done = (c % period) == WS0 + 2;
         checks++;
         if (done[0] !== exp_done || busy[0] !== exp_busy || (exp_done && rdo[0] !== w)) begin
            errors++;
            $display("FAIL held_read c=%0d: done=%b busy=%b rd=%h, required %b %b %h", c, done[0], busy[0], rdo[0], exp_done, exp_busy, w);
         end
      end
      re[0] = 0;
      last_rd[0] = w;
   endtask

   task automatic test_random;
      int dc, bc; bit e; logic [31:0] r, a, d;
      bit rr, ww, bad;
      int kind, exp_dc, exp_bc;
      logic [31:0] exp_rd;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         d = $urandom;
         a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
         rr = 0; ww = 0; bad = 1;
         case (kind)
            0: begin a = a | 32'($urandom_range(1, 3)); rr = $urandom_range(0, 1); ww = !rr; end
            1: begin a = ($urandom | 32'h1000) & 32'hFFFF_FFFC; rr = $urandom_range(0, 1); ww = !rr; end
            2: begin rr = 1; ww = 1; end
            default: begin
               bad = 0;
               if (known1.size() == 0 || $urandom_range(0, 1) == 0) ww = 1;
               else begin
                  rr = 1;
                  a = 32'(known1[$urandom_range(0, known1.size() - 1)]) << 2;
               end
            end
         endcase
         xact(1, rr, ww, a, d, dc, bc, e, r);
         exp_dc = bad ? 1 : WS1 + 2;
         exp_bc = bad ? 0 : WS1 + 1;
         if (!bad && ww) begin mem_m[key(1, a)] = d; known1.push_back(int'(a[11:2])); end
         if (!bad && rr) last_rd[1] = mem_m[key(1, a)];
         exp_rd = last_rd[1];
         checks++;
         if (dc !== exp_dc || bc !== exp_bc || e !== bad || r !== exp_rd) begin
            errors++;
            $display("FAIL random_%0d addr=%h r=%b w=%b: done_cycle=%0d busy=%0d err=%b data=%h, required %0d %0d %b %h",
                     i, a, rr, ww, dc, bc, e, r, exp_dc, exp_bc, bad, exp_rd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_errors();
      test_midflight();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface. It services word reads and writes issued by the CPU.
- Holds a word-addressed RAM and inserts a configurable number of wait states.
- Signals completion with busy and done, so the CPU can stall on memory instead of assuming single-cycle access.
- Flags illegal requests: misaligned address, out-of-range address, or read and write asserted together.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth is 2**ADDR_WIDTH words, byte span 2**(ADDR_WIDTH+2).
WAIT_STATES, 2, extra cycles between accept and access; 0 is legal.
DATA_WIDTH, 32, word width.

Ports:
Clk  input  1  clock; all state changes on rising edge.
Reset  input  1  synchronous active-high reset.
mem_read_enable  input  1  read request.
mem_write_enable  input  1  write request.
mem_addr  input  32  byte address from ALU result.
mem_write_data_in  input  DATA_WIDTH  write data.
mem_read_data_out  output  DATA_WIDTH  last successfully read word.
busy  output  1  request in flight; CPU must stall.
done  output  1  one-cycle completion pulse.
err  output  1  one-cycle illegal-request pulse.

Behaviour:
- Reset: on the edge with Reset=1, state=IDLE, wait counter=0, mem_read_data_out=0, busy=0, done=0, err=0. RAM contents are not cleared and are undefined after power-up. Reset takes priority over every other event.
- States: IDLE, WAIT, DONE. All outputs are registered.
- IDLE, no request: remain in IDLE.
- IDLE, illegal request: any of the following is illegal:
  - mem_read_enable and mem_write_enable both 1;
  - mem_addr[1:0] != 0;
  - mem_addr[31:ADDR_WIDTH+2] != 0 (out of range).
  - Response: next cycle err=1 and done=1 for one cycle (state DONE). No RAM change, mem_read_data_out unchanged, busy stays 0.
- IDLE, legal request: on edge k, latch op, word index mem_addr[ADDR_WIDTH+1:2] and write data; counter=WAIT_STATES; state=WAIT; busy=1 from edge k.
- WAIT: on each edge, if counter!=0 then decrement; else perform the access:
  - write: RAM[index] <= latched data;
  - read: mem_read_data_out <= RAM[index];
  - then busy=0, done=1, state=DONE.
  - Access edge is k+WAIT_STATES+1. done is high in the cycle following that edge.
  - Inputs during WAIT are ignored; latched values are used, so changes to the request mid-flight have no effect.
- DONE: lasts exactly one cycle. done=1 and err as set. Requests sampled in this cycle are ignored, so a request the CPU is still holding is not re-accepted. Next state is IDLE.
- Throughput: minimum spacing between accepts is WAIT_STATES+3 cycles.
- mem_read_data_out changes only on a successful read access or on reset. Writes and illegal requests leave it unchanged.
- Write-then-read to the same index returns the written data. There is no forwarding concern because accesses are serialized.
- Reset during WAIT, including the access edge: the access is aborted, no RAM write occurs, and state returns to IDLE.
- Address wrap: no wrap. Out-of-range addresses are errors, not aliased.

Test Plan:
1. Reset with all inputs 0 -> next cycle busy=0, done=0, err=0, mem_read_data_out=0; after 5 idle cycles outputs are still 0.
2. WAIT_STATES=2: write 0xDEADBEEF to addr 0x10, request held until done -> busy high for 3 cycles, done high in the 4th cycle after accept. Then read addr 0x10 -> mem_read_data_out=0xDEADBEEF in the done cycle, busy for 3 cycles.
3. Read addr 0x12 (misaligned), then addr 0x1000 (out of range at ADDR_WIDTH=10), then read and write both 1 at 0x20 -> each gives err=1 and done=1 for one cycle, busy never 1. A subsequent read of 0x20 returns its prior contents, and mem_read_data_out keeps its previous value throughout the three errors.
4. During WAIT, change mem_addr to 0x40 and mem_write_data_in to 0x1 -> access uses the latched 0x10 and 0xDEADBEEF; a later read of 0x40 shows its old value.
5. Write 0x12345678 to 0x8, then assert Reset on the access edge -> no write occurs; a later read of 0x8 returns its pre-write value and busy drops after the reset edge.
6. WAIT_STATES=0: CPU holds a read of 0x4 continuously for 10 cycles -> accept, busy 1 cycle, done 1 cycle, then re-accept. done pulses every 3 cycles, never 2 in a row.
